// File: rtl/store_align_unit.sv
// store_align_unit: turns one store request into bus-word-aligned beats.
// Each beat carries a byte-enable mask and lane-shifted write data.
// Optional feature macro: STORE_MISALIGN_SPLIT_EN.
//   defined   : a store that crosses a bus word is issued as two beats
//               (BEAT0, then BEAT1).
//   undefined : any store not aligned to its size faults, and the BEAT1
//               datapath is not built.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// BEAT0 | first (or only) beat presented on the bus
// BEAT1 | upper beat of a word-crossing store
module store_align_unit #(
    parameter int XLEN = 32,
    localparam int BUS_BYTES = XLEN / 8,
    localparam int OFF_W = $clog2(BUS_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_data,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [BUS_BYTES-1:0] mem_mask,
    output logic                 done,
    output logic                 fault
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    localparam logic [XLEN-1:0] BEAT_STRIDE = XLEN'(BUS_BYTES);

    state_t state, state_n;

    logic [OFF_W-1:0]       off;
    logic [BUS_BYTES-1:0]   byte_mask;
    logic [XLEN-1:0]        size_bits;
    logic [OFF_W-1:0]       align_bits;
    logic [2*BUS_BYTES-1:0] wide_mask;
    logic [2*XLEN-1:0]      wide_data;
    logic [XLEN-1:0]        base;
    logic                   illegal;
    logic                   reject;
    logic                   load_lo;
    logic                   done_n;
    logic                   fault_n;

`ifdef STORE_MISALIGN_SPLIT_EN
    logic                   go_hi;
    logic                   has_hi;
    logic [BUS_BYTES-1:0]   hi_mask;
    logic [XLEN-1:0]        hi_data;
`endif

    assign off       = req_addr[OFF_W-1:0];
    assign base      = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign illegal   = req_funct3[2] | ((req_funct3[1:0] == 2'b11) && (XLEN == 32));
    assign mem_valid = (state != IDLE);
    assign req_ready = (state == IDLE) && !rst;

    // Size decode: byte mask, data bits kept, and address bits that must be zero when aligned.
    always_comb begin
        byte_mask  = '0;
        size_bits  = '0;
        align_bits = '0;
        case (req_funct3[1:0])
            2'b00: begin
                byte_mask  = BUS_BYTES'(1'b1);
                size_bits  = XLEN'(8'hFF);
            end
            2'b01: begin
                byte_mask  = BUS_BYTES'(2'b11);
                size_bits  = XLEN'(16'hFFFF);
                align_bits = OFF_W'(1);
            end
            2'b10: begin
                byte_mask  = BUS_BYTES'(4'hF);
                size_bits  = XLEN'(32'hFFFF_FFFF);
                align_bits = OFF_W'(3);
            end
            default: begin
                byte_mask  = '1;
                size_bits  = '1;
                align_bits = OFF_W'(7);
            end
        endcase
    end

    // Data is trimmed to the store size so unused lanes always carry zero.
    assign wide_mask = {{BUS_BYTES{1'b0}}, byte_mask} << off;
    assign wide_data = {{XLEN{1'b0}}, (req_data & size_bits)} << {off, 3'b000};

`ifdef STORE_MISALIGN_SPLIT_EN
    logic unused_align;
    assign unused_align = ^align_bits;
    assign reject = illegal;
`else
    logic unused_hi;
    assign unused_hi = ^{wide_mask[2*BUS_BYTES-1:BUS_BYTES], wide_data[2*XLEN-1:XLEN]};
    assign reject = illegal | (|(off & align_bits));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and control strobes.
    always_comb begin
        state_n = state;
        load_lo = 1'b0;
        done_n  = 1'b0;
        fault_n = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        go_hi   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        fault_n = 1'b1;
                    end else begin
                        load_lo = 1'b1;
                        state_n = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (has_hi) begin
                        go_hi   = 1'b1;
                        state_n = BEAT1;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
`else
                    done_n  = 1'b1;
                    state_n = IDLE;
`endif
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (mem_ready) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Beat datapath and status pulses; beat fields change only on load or beat advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            has_hi    <= 1'b0;
            hi_mask   <= '0;
            hi_data   <= '0;
`endif
        end else begin
            done  <= done_n;
            fault <= fault_n;
            if (load_lo) begin
                mem_addr  <= base;
                mem_mask  <= wide_mask[BUS_BYTES-1:0];
                mem_wdata <= wide_data[XLEN-1:0];
`ifdef STORE_MISALIGN_SPLIT_EN
                has_hi    <= |wide_mask[2*BUS_BYTES-1:BUS_BYTES];
                hi_mask   <= wide_mask[2*BUS_BYTES-1:BUS_BYTES];
                hi_data   <= wide_data[2*XLEN-1:XLEN];
`endif
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            else if (go_hi) begin
                mem_addr  <= mem_addr + BEAT_STRIDE;
                mem_mask  <= hi_mask;
                mem_wdata <= hi_data;
            end
`endif
        end
    end

`ifndef STORE_MISALIGN_SPLIT_EN
    logic unused_stride;
    assign unused_stride = ^BEAT_STRIDE;
`endif

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (XLEN=32). Expectations follow the
// STORE_MISALIGN_SPLIT_EN setting of the build.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        done;
    logic        fault;

    int checks = 0;
    int errors = 0;

    store_align_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge of cycle N+1.
    task automatic send(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        req_addr   = a;
        req_funct3 = f3;
        req_data   = d;
        req_valid  = 1'b1;
        chk("req_ready_before", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        chk({tag, "_valid"}, mem_valid, 1);
        chk({tag, "_addr"},  mem_addr, a);
        chk({tag, "_mask"},  mem_mask, m);
        chk({tag, "_wdata"}, mem_wdata, d);
        chk({tag, "_rdy0"},  req_ready, 0);
        chk({tag, "_nodone"}, done, 0);
    endtask

    // Called in the cycle after the last handshake.
    task automatic expect_done(input string tag);
        chk({tag, "_done"},   done, 1);
        chk({tag, "_nofault"}, fault, 0);
        chk({tag, "_rdy1"},   req_ready, 1);
        chk({tag, "_vld0"},   mem_valid, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    // Called in cycle N+1 of a rejected request.
    task automatic expect_fault(input string tag);
        chk({tag, "_fault"},  fault, 1);
        chk({tag, "_nodone"}, done, 0);
        chk({tag, "_rdy1"},   req_ready, 1);
        chk({tag, "_vld0"},   mem_valid, 0);
        @(negedge clk);
        chk({tag, "_fault_pulse"}, fault, 0);
        chk({tag, "_vld_still0"}, mem_valid, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_mask",  mem_mask, 0);
        chk("rst_done",  done, 0);
        chk("rst_fault", fault, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Aligned SW
        send(32'h0000_1000, 3'b010, 32'hDEAD_BEEF);
        beat("sw", 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        expect_done("sw");

        // SB at offset 3, upper data bits must not leak
        send(32'h0000_1003, 3'b000, 32'hFFFF_FFA5);
        beat("sb", 32'h0000_1000, 4'b1000, 32'hA500_0000);
        @(negedge clk);
        expect_done("sb");

        // SH at offset 2
        send(32'h0000_1002, 3'b001, 32'h0000_1234);
        beat("sh", 32'h0000_1000, 4'b1100, 32'h1234_0000);
        @(negedge clk);
        expect_done("sh");

        // SH crossing a word
        send(32'h0000_1003, 3'b001, 32'h0000_1234);
`ifdef STORE_MISALIGN_SPLIT_EN
        beat("shx0", 32'h0000_1000, 4'b1000, 32'h3400_0000);
        @(negedge clk);
        beat("shx1", 32'h0000_1004, 4'b0001, 32'h0000_0012);
        @(negedge clk);
        expect_done("shx");
`else
        expect_fault("shx");
`endif

        // SH misaligned inside one word
        send(32'h0000_1001, 3'b001, 32'h0000_ABCD);
`ifdef STORE_MISALIGN_SPLIT_EN
        beat("shm", 32'h0000_1000, 4'b0110, 32'h00AB_CD00);
        @(negedge clk);
        expect_done("shm");
`else
        expect_fault("shm");
`endif

        // Back-pressure on an aligned SW: 3 stalled cycles
        mem_ready = 1'b0;
        send(32'h0000_2000, 3'b010, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("stall%0d", i), 32'h0000_2000, 4'b1111, 32'h1122_3344);
            @(negedge clk);
        end
        beat("stall3", 32'h0000_2000, 4'b1111, 32'h1122_3344);
        mem_ready = 1'b1;
        @(negedge clk);
        expect_done("stall");

        // Misaligned SW 0x1001 with stall
        mem_ready = 1'b0;
        send(32'h0000_1001, 3'b010, 32'h1122_3344);
`ifdef STORE_MISALIGN_SPLIT_EN
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("swm_stall%0d", i), 32'h0000_1000, 4'b1110, 32'h2233_4400);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        beat("swm0", 32'h0000_1000, 4'b1110, 32'h2233_4400);
        @(negedge clk);
        beat("swm1", 32'h0000_1004, 4'b0001, 32'h0000_0011);
        @(negedge clk);
        expect_done("swm");
`else
        mem_ready = 1'b1;
        expect_fault("swm");
`endif

        // Address wrap at the top of memory
        send(32'hFFFF_FFFE, 3'b010, 32'hAABB_CCDD);
`ifdef STORE_MISALIGN_SPLIT_EN
        beat("wrap0", 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000);
        @(negedge clk);
        beat("wrap1", 32'h0000_0000, 4'b0011, 32'h0000_AABB);
        @(negedge clk);
        expect_done("wrap");
`else
        expect_fault("wrap");
`endif

        // Illegal funct3 values
        send(32'h0000_1000, 3'b011, 32'h0);
        expect_fault("sd32");
        send(32'h0000_1000, 3'b100, 32'h0);
        expect_fault("f3_100");

        // Reset while a beat is outstanding
        mem_ready = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        mem_ready = 1'b1;
        send(32'h0000_1003, 3'b001, 32'h0000_1234);
        beat("rx0", 32'h0000_1000, 4'b1000, 32'h3400_0000);
        @(negedge clk);
        mem_ready = 1'b0;
        beat("rx1", 32'h0000_1004, 4'b0001, 32'h0000_0012);
`else
        send(32'h0000_3000, 3'b010, 32'h5555_AAAA);
        beat("rx0", 32'h0000_3000, 4'b1111, 32'h5555_AAAA);
`endif
        #2 rst = 1'b1;
        #1;
        chk("rx_vld0",   mem_valid, 0);
        chk("rx_nodone", done, 0);
        chk("rx_nofault", fault, 0);
        chk("rx_rdy0",   req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rx_rdy_after", req_ready, 1);
        @(negedge clk);
        chk("rx_nodone_after", done, 0);
        send(32'h0000_4000, 3'b010, 32'hCAFE_F00D);
        beat("post", 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
        @(negedge clk);
        expect_done("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
